// File: rtl/aes_reg_bank_pkg.sv
// Shared register map, bit positions and STATUS layout for the AES-128 register bank.
package aes_reg_bank_pkg;

    localparam logic [6:0] REG_CTRL    = 7'h00;
    localparam logic [6:0] REG_STATUS  = 7'h04;
    localparam logic [6:0] REG_KEY0    = 7'h10;
    localparam logic [6:0] REG_PT0     = 7'h20;
    localparam logic [6:0] REG_CT0     = 7'h30;
    localparam logic [6:0] REG_VERSION = 7'h40;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

    typedef struct packed {
        logic [28:0] rsvd;
        logic        err;
        logic        done;
        logic        busy;
    } status_t;

    function automatic logic [4:0] word_of(input logic [6:0] byte_addr);
        return byte_addr[6:2];
    endfunction

    // KEY/PT/CT banks are four words aligned on a 16-byte boundary
    function automatic logic in_bank(input logic [4:0] word, input logic [6:0] base);
        return word[4:2] == base[6:4];
    endfunction

endpackage

// File: rtl/aes_reg_bank_wstrb_reg32.sv
// 32-bit register with per-byte write strobes and asynchronous active-high reset.
module wstrb_reg32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wstrb,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) q[8*b +: 8] <= d[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/aes_reg_bank.sv
// Memory-mapped control/status/operand/result registers between the AXI4-Lite
// slave memory port and the AES-128 datapath.
module aes_reg_bank
    import aes_reg_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] VERSION    = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_read,
    input  logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic                    core_start,
    output logic [127:0]            core_key,
    output logic [127:0]            core_plaintext,
    input  logic                    core_done,
    input  logic [127:0]            core_ciphertext,
    output logic                    irq
);

    logic [4:0]            wr_word;
    logic [4:0]            rd_word;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  wr_key;
    logic                  wr_pt;
    logic                  start_req;
    logic                  done_evt;

    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  irq_en;

    logic [3:0]            key_we;
    logic [3:0]            pt_we;
    logic [31:0]           key_q [4];
    logic [31:0]           pt_q  [4];
    logic [31:0]           ct_q  [4];

    status_t               status;
    logic [DATA_WIDTH-1:0] rd_val;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{mem_wr_addr[1:0], mem_rd_addr[1:0]};

    assign wr_word   = mem_wr_addr[ADDR_WIDTH-1:2];
    assign rd_word   = mem_rd_addr[ADDR_WIDTH-1:2];
    assign wr_ctrl   = mem_write && (wr_word == word_of(REG_CTRL));
    assign wr_status = mem_write && (wr_word == word_of(REG_STATUS));
    assign wr_key    = mem_write && in_bank(wr_word, REG_KEY0);
    assign wr_pt     = mem_write && in_bank(wr_word, REG_PT0);
    assign start_req = wr_ctrl && mem_wstrb[0] && mem_data_in[CTRL_START];
    // Completion only counts while an operation is outstanding
    assign done_evt  = core_done && busy;

    // Operands are frozen while busy so the datapath sees stable key/plaintext
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            key_we[i] = wr_key && !busy && (wr_word[1:0] == 2'(i));
            pt_we[i]  = wr_pt  && !busy && (wr_word[1:0] == 2'(i));
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_operand
        wstrb_reg32 u_key (
            .clk   (clk),
            .reset (reset),
            .we    (key_we[i]),
            .wstrb (mem_wstrb),
            .d     (mem_data_in),
            .q     (key_q[i])
        );
        wstrb_reg32 u_pt (
            .clk   (clk),
            .reset (reset),
            .we    (pt_we[i]),
            .wstrb (mem_wstrb),
            .d     (mem_data_in),
            .q     (pt_q[i])
        );
    end

    assign core_key       = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign core_plaintext = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};

    // Control state; core_done is applied last so a same-cycle DONE W1C loses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            irq_en     <= 1'b0;
            core_start <= 1'b0;
            irq        <= 1'b0;
        end else begin
            core_start <= 1'b0;
            irq        <= done && irq_en;
            if (wr_ctrl && mem_wstrb[0]) irq_en <= mem_data_in[CTRL_IRQ_EN];
            if (start_req) begin
                if (busy) begin
                    err <= 1'b1;
                end else begin
                    core_start <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                end
            end
            if ((wr_key || wr_pt) && busy) err <= 1'b1;
            if (wr_status && mem_wstrb[0]) begin
                if (mem_data_in[STATUS_DONE]) done <= 1'b0;
                if (mem_data_in[STATUS_ERR])  err  <= 1'b0;
            end
            if (done_evt) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) ct_q[i] <= '0;
        end else if (done_evt) begin
            for (int i = 0; i < 4; i++) ct_q[i] <= core_ciphertext[127-32*i -: 32];
        end
    end

    always_comb begin
        status      = '0;
        status.busy = busy;
        status.done = done;
        status.err  = err;
        rd_val      = '0;
        if (rd_word == word_of(REG_CTRL)) begin
            rd_val[CTRL_IRQ_EN] = irq_en;
        end else if (rd_word == word_of(REG_STATUS)) begin
            rd_val = status;
        end else if (in_bank(rd_word, REG_KEY0)) begin
            rd_val = key_q[rd_word[1:0]];
        end else if (in_bank(rd_word, REG_PT0)) begin
            rd_val = pt_q[rd_word[1:0]];
        end else if (in_bank(rd_word, REG_CT0)) begin
            rd_val = ct_q[rd_word[1:0]];
        end else if (rd_word == word_of(REG_VERSION)) begin
            rd_val = VERSION;
        end
    end

    // Stage p1: read data registered on the edge after mem_read, held otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_p1 <= '0;
        end else if (mem_read) begin
            rd_data_p1 <= rd_val;
        end
    end

    assign mem_data_out = rd_data_p1;

endmodule

// File: tb/tb_aes_reg_bank.sv
// Directed and randomized checks of aes_reg_bank against a register-map model.
module tb_aes_reg_bank;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mem_write = 1'b0;
    logic [6:0]   mem_wr_addr = '0;
    logic [31:0]  mem_data_in = '0;
    logic [3:0]   mem_wstrb = '0;
    logic         mem_read = 1'b0;
    logic [6:0]   mem_rd_addr = '0;
    logic [31:0]  mem_data_out;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_plaintext;
    logic         core_done = 1'b0;
    logic [127:0] core_ciphertext = '0;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    aes_reg_bank dut (
        .clk             (clk),
        .reset           (reset),
        .mem_write       (mem_write),
        .mem_wr_addr     (mem_wr_addr),
        .mem_data_in     (mem_data_in),
        .mem_wstrb       (mem_wstrb),
        .mem_read        (mem_read),
        .mem_rd_addr     (mem_rd_addr),
        .mem_data_out    (mem_data_out),
        .core_start      (core_start),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (core_done),
        .core_ciphertext (core_ciphertext),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    // Register-map model: word-addressed arrays plus the three status flags
    logic [31:0] m_key [4];
    logic [31:0] m_pt  [4];
    logic [31:0] m_ct  [4];
    logic        m_busy, m_done, m_err, m_irq_en, m_irq, m_start;
    logic [31:0] m_rdata;

    logic [31:0] nk [4];
    logic [31:0] np [4];
    logic [31:0] nc [4];
    logic        nb, nd, ne, nie;
    logic [31:0] nrd;
    int          w;

    function automatic logic [31:0] model_read(input logic [6:0] a);
        int wi;
        wi = int'(a[6:2]);
        if (wi == 0)                return {30'b0, m_irq_en, 1'b0};
        if (wi == 1)                return {29'b0, m_err, m_done, m_busy};
        if (wi >= 4  && wi <= 7)    return m_key[wi-4];
        if (wi >= 8  && wi <= 11)   return m_pt[wi-8];
        if (wi >= 12 && wi <= 15)   return m_ct[wi-12];
        if (wi == 16)               return 32'h0001_0000;
        return 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_key[i] = '0; m_pt[i] = '0; m_ct[i] = '0;
            end
            m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_irq = 0; m_start = 0;
            m_rdata = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                nk[i] = m_key[i]; np[i] = m_pt[i]; nc[i] = m_ct[i];
            end
            nb = m_busy; nd = m_done; ne = m_err; nie = m_irq_en;
            nrd = mem_read ? model_read(mem_rd_addr) : m_rdata;
            m_start = 0;
            if (mem_write) begin
                w = int'(mem_wr_addr[6:2]);
                if (w == 0 && mem_wstrb[0]) begin
                    nie = mem_data_in[1];
                    if (mem_data_in[0]) begin
                        if (m_busy) ne = 1;
                        else begin m_start = 1; nb = 1; nd = 0; end
                    end
                end else if (w == 1 && mem_wstrb[0]) begin
                    if (mem_data_in[1]) nd = 0;
                    if (mem_data_in[2]) ne = 0;
                end else if (w >= 4 && w <= 11) begin
                    if (m_busy) ne = 1;
                    else if (w < 8) nk[w-4] = merge(m_key[w-4], mem_data_in, mem_wstrb);
                    else np[w-8] = merge(m_pt[w-8], mem_data_in, mem_wstrb);
                end
            end
            if (core_done && m_busy) begin
                nb = 0; nd = 1;
                for (int i = 0; i < 4; i++) nc[i] = core_ciphertext[127-32*i -: 32];
            end
            m_irq = m_done & m_irq_en;
            for (int i = 0; i < 4; i++) begin
                m_key[i] = nk[i]; m_pt[i] = np[i]; m_ct[i] = nc[i];
            end
            m_busy = nb; m_done = nd; m_err = ne; m_irq_en = nie; m_rdata = nrd;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("mem_data_out", {96'b0, mem_data_out}, {96'b0, m_rdata});
        chk("core_start", {127'b0, core_start}, {127'b0, m_start});
        chk("irq", {127'b0, irq}, {127'b0, m_irq});
        chk("core_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
        chk("core_plaintext", core_plaintext, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        mem_write = 0; mem_read = 0; core_done = 0;
        tick();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_write = 1; mem_wr_addr = a; mem_data_in = d; mem_wstrb = s;
        tick();
        mem_write = 0;
    endtask

    task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
        mem_read = 1; mem_rd_addr = a;
        tick();
        mem_read = 0;
        chk(name, {96'b0, mem_data_out}, {96'b0, exp});
    endtask

    function automatic logic [6:0] pick_addr();
        logic [6:0] lo;
        lo = 7'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0, 7:    return 7'h00 | lo;
            1:       return 7'h04 | lo;
            2:       return 7'h10 + 7'($urandom_range(0, 3) * 4) + lo;
            3:       return 7'h20 + 7'($urandom_range(0, 3) * 4) + lo;
            4:       return 7'h30 + 7'($urandom_range(0, 3) * 4) + lo;
            5:       return 7'h40 | lo;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_irq", {127'b0, irq}, 128'h0);
        chk("rst_rdata", {96'b0, mem_data_out}, 128'h0);
        chk("rst_start", {127'b0, core_start}, 128'h0);
        rd_chk("version", 7'h40, 32'h0001_0000);
        rd_chk("rst_status", 7'h04, 32'h0);
        rd_chk("rst_ct0", 7'h30, 32'h0);

        // Byte-strobed KEY0
        wr(7'h10, 32'h2B7E1516, 4'b0011);
        wr(7'h10, 32'hAABBCCDD, 4'b1100);
        rd_chk("key0_strobe", 7'h10, 32'hAABB1516);
        chk("core_key0", {96'b0, core_key[127:96]}, {96'b0, 32'hAABB1516});
        chk("model_key0", {96'b0, m_key[0]}, {96'b0, 32'hAABB1516});

        // Start, completion, irq
        wr(7'h00, 32'h3, 4'hF);
        chk("start_pulse", {127'b0, core_start}, 128'h1);
        idle();
        chk("start_drop", {127'b0, core_start}, 128'h0);
        rd_chk("status_busy", 7'h04, 32'h1);
        core_done = 1;
        core_ciphertext = 128'h3925841D_02DC09FB_DC118597_196A0B32;
        tick();
        core_done = 0;
        chk("irq_lag", {127'b0, irq}, 128'h0);
        rd_chk("status_done", 7'h04, 32'h2);
        chk("irq_set", {127'b0, irq}, 128'h1);
        rd_chk("ct0", 7'h30, 32'h3925841D);
        rd_chk("ct3", 7'h3C, 32'h196A0B32);
        chk("model_ct1", {96'b0, m_ct[1]}, {96'b0, 32'h02DC09FB});

        // Writes while busy
        wr(7'h24, 32'hCAFEF00D, 4'hF);
        wr(7'h00, 32'h3, 4'hF);
        chk("start2_pulse", {127'b0, core_start}, 128'h1);
        wr(7'h00, 32'h1, 4'hF);
        chk("busy_start_ignored", {127'b0, core_start}, 128'h0);
        wr(7'h24, 32'h12345678, 4'hF);
        rd_chk("pt1_frozen", 7'h24, 32'hCAFEF00D);
        chk("core_pt1", {96'b0, core_plaintext[95:64]}, {96'b0, 32'hCAFEF00D});
        rd_chk("status_err", 7'h04, 32'h5);
        wr(7'h04, 32'h4, 4'h1);
        rd_chk("status_w1c_err", 7'h04, 32'h1);

        // core_done beats a same-cycle DONE W1C
        core_done = 1;
        core_ciphertext = {$urandom, $urandom, $urandom, $urandom};
        wr(7'h04, 32'h2, 4'h1);
        core_done = 0;
        rd_chk("done_set_wins", 7'h04, 32'h2);

        // Reset abandons an operation
        wr(7'h00, 32'h3, 4'hF);
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        core_done = 1;
        core_ciphertext = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
        tick();
        core_done = 0;
        rd_chk("rst_abandon_status", 7'h04, 32'h0);
        rd_chk("rst_abandon_ct0", 7'h30, 32'h0);
        chk("rst_abandon_irq", {127'b0, irq}, 128'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            mem_write = ($urandom_range(0, 99) < 35);
            mem_wr_addr = pick_addr();
            mem_data_in = $urandom;
            if ($urandom_range(0, 1) == 1) mem_data_in[0] = 1'b1;
            mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            mem_read = ($urandom_range(0, 1) == 1);
            mem_rd_addr = pick_addr();
            core_done = ($urandom_range(0, 99) < 8);
            core_ciphertext = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 499) == 0);
            tick();
            reset = 0;
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
